// File: rtl/comm_master_gen.sv
// Wireless-link command master: frames {cmd, payload} onto an 8N1 UART, then waits
// for a one-byte response from the copter, resending the frame on timeout.
module comm_master_gen #(
  parameter int         DATA_BYTES   = 2,
  parameter int         BAUD_DIV     = 2604,
  parameter int         RESP_TIMEOUT = 5000000,
  parameter int         MAX_RETRY    = 2,
  parameter logic [7:0] ACK_VAL      = 8'hA5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              cmd,
  input  logic [8*DATA_BYTES-1:0] data,
  input  logic                    snd_cmd,
  input  logic                    clr_resp_rdy,
  input  logic                    RX,
  output logic                    TX,
  output logic                    busy,
  output logic                    frm_snt,
  output logic                    resp_rdy,
  output logic [7:0]              resp,
  output logic                    resp_ack,
  output logic                    timeout,
  output logic [2:0]              retry_cnt,
  output logic [2:0]              o_dbg_state,
  output logic [1:0]              o_dbg_rx_state
);

  localparam int              SHW       = 8 * (DATA_BYTES + 1);
  localparam int              TOW       = $clog2(RESP_TIMEOUT + 1);
  localparam logic [11:0]     BAUD_LAST = 12'(BAUD_DIV - 1);
  localparam logic [11:0]     BAUD_PRE  = 12'(BAUD_DIV - 2);
  localparam logic [11:0]     BAUD_HALF = 12'(BAUD_DIV / 2 - 1);
  localparam logic [TOW-1:0]  TO_LAST   = TOW'(RESP_TIMEOUT - 1);
  localparam logic [TOW-1:0]  TO_SAT    = '1;
  localparam logic [2:0]      RETRY_MAX = 3'(MAX_RETRY);
  localparam logic [2:0]      LAST_BYTE = 3'(DATA_BYTES);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_TX_BYTE, S_WAIT_RESP, S_DONE} state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  state_t         r_state;
  logic [SHW-1:0] r_shadow;
  logic [2:0]     r_byte_idx;
  logic [8:0]     r_tx_shift;
  logic [3:0]     r_tx_bit;
  logic [11:0]    r_tx_baud;
  logic [TOW-1:0] r_to_cnt;
  logic           r_tx;
  logic           r_busy;
  logic           r_frm_snt;
  logic           r_resp_rdy;
  logic [7:0]     r_resp;
  logic           r_timeout;
  logic [2:0]     r_retry_cnt;
  logic [7:0]     w_load_byte;

  rx_state_t      r_rx_state;
  logic           r_rx_s1;
  logic           r_rx_s2;
  logic           r_rx_d;
  logic [11:0]    r_rx_baud;
  logic [2:0]     r_rx_bit;
  logic [7:0]     r_rx_shift;
  logic           r_rx_valid;
  logic [7:0]     r_rx_byte;

  // Byte 0 is cmd; payload bytes follow, most significant byte first.
  always_comb begin
    w_load_byte = '0;
    for (int i = 0; i <= DATA_BYTES; i++) begin
      if (r_byte_idx == 3'(i)) w_load_byte = r_shadow[SHW-1-8*i -: 8];
    end
  end

  // Request handshake: snd_cmd is a one-cycle request, accepted only while busy=0;
  // busy stays high from acceptance until the FSM is back in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_shadow    <= '0;
      r_byte_idx  <= '0;
      r_tx_shift  <= '1;
      r_tx_bit    <= '0;
      r_tx_baud   <= '0;
      r_to_cnt    <= '0;
      r_tx        <= 1'b1;
      r_busy      <= 1'b0;
      r_frm_snt   <= 1'b0;
      r_resp_rdy  <= 1'b0;
      r_resp      <= 8'h00;
      r_timeout   <= 1'b0;
      r_retry_cnt <= '0;
    end else begin
      r_frm_snt <= 1'b0;
      if (clr_resp_rdy) r_resp_rdy <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (snd_cmd) begin
            r_shadow    <= {cmd, data};
            r_busy      <= 1'b1;
            r_resp_rdy  <= 1'b0;
            r_timeout   <= 1'b0;
            r_retry_cnt <= '0;
            r_byte_idx  <= '0;
            r_state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_tx       <= 1'b0;
          r_tx_shift <= {1'b1, w_load_byte};
          r_tx_bit   <= '0;
          r_tx_baud  <= '0;
          r_state    <= S_TX_BYTE;
        end
        S_TX_BYTE: begin
          // The stop bit ends one cycle early here: the following LOAD or the
          // first WAIT_RESP cycle supplies its final cycle, so bytes abut.
          if (r_tx_bit == 4'd9 && r_tx_baud == BAUD_PRE) begin
            r_tx_baud <= '0;
            if (r_byte_idx == LAST_BYTE) begin
              r_frm_snt <= 1'b1;
              r_to_cnt  <= '0;
              r_state   <= S_WAIT_RESP;
            end else begin
              r_byte_idx <= r_byte_idx + 3'd1;
              r_state    <= S_LOAD;
            end
          end else if (r_tx_baud == BAUD_LAST) begin
            r_tx_baud  <= '0;
            r_tx_bit   <= r_tx_bit + 4'd1;
            r_tx       <= r_tx_shift[0];
            r_tx_shift <= {1'b1, r_tx_shift[8:1]};
          end else begin
            r_tx_baud <= r_tx_baud + 12'd1;
          end
        end
        S_WAIT_RESP: begin
          if (r_to_cnt != TO_SAT) r_to_cnt <= r_to_cnt + 1'b1;
          if (r_rx_valid) begin
            r_resp     <= r_rx_byte;
            r_resp_rdy <= 1'b1;
            r_state    <= S_DONE;
          end else if (r_to_cnt == TO_LAST) begin
            if (r_retry_cnt < RETRY_MAX) begin
              r_retry_cnt <= r_retry_cnt + 3'd1;
              r_byte_idx  <= '0;
              r_state     <= S_LOAD;
            end else begin
              r_timeout <= 1'b1;
              r_state   <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Free-running receiver; start bit re-checked at half-bit to reject glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_d     <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_baud  <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_valid <= 1'b0;
      r_rx_byte  <= '0;
    end else begin
      r_rx_s1    <= RX;
      r_rx_s2    <= r_rx_s1;
      r_rx_d     <= r_rx_s2;
      r_rx_valid <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (r_rx_d && !r_rx_s2) begin
            r_rx_baud  <= '0;
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (r_rx_baud == BAUD_HALF) begin
            r_rx_baud  <= '0;
            r_rx_bit   <= '0;
            r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_baud <= r_rx_baud + 12'd1;
          end
        end
        RX_DATA: begin
          if (r_rx_baud == BAUD_LAST) begin
            r_rx_baud  <= '0;
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
            else                  r_rx_bit   <= r_rx_bit + 3'd1;
          end else begin
            r_rx_baud <= r_rx_baud + 12'd1;
          end
        end
        RX_STOP: begin
          if (r_rx_baud == BAUD_LAST) begin
            r_rx_baud  <= '0;
            r_rx_state <= RX_IDLE;
            if (r_rx_s2) begin
              r_rx_valid <= 1'b1;
              r_rx_byte  <= r_rx_shift;
            end
          end else begin
            r_rx_baud <= r_rx_baud + 12'd1;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  assign TX             = r_tx;
  assign busy           = r_busy;
  assign frm_snt        = r_frm_snt;
  assign resp_rdy       = r_resp_rdy;
  assign resp           = r_resp;
  assign resp_ack       = r_resp_rdy && (r_resp == ACK_VAL);
  assign timeout        = r_timeout;
  assign retry_cnt      = r_retry_cnt;
  assign o_dbg_state    = r_state;
  assign o_dbg_rx_state = r_rx_state;

endmodule

// File: tb/tb_comm_master_gen.sv
// Directed bench for comm_master_gen: frame table, retry/timeout sequences,
// receiver corner cases, with a UART decoder on TX feeding an expected-byte queue.
module tb_comm_master_gen;

  localparam int         DB  = 2;
  localparam int         BD  = 16;
  localparam int         RT  = 2000;
  localparam int         MR  = 2;
  localparam logic [7:0] ACK = 8'hA5;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    cmd;
  logic [8*DB-1:0] data;
  logic          snd_cmd;
  logic          clr_resp_rdy;
  logic          rx;
  logic          tx_w;
  logic          busy;
  logic          frm_snt;
  logic          resp_rdy;
  logic [7:0]    resp;
  logic          resp_ack;
  logic          timeout;
  logic [2:0]    retry_cnt;
  logic [2:0]    dbg_state;
  logic [1:0]    dbg_rx_state;

  comm_master_gen #(
    .DATA_BYTES(DB), .BAUD_DIV(BD), .RESP_TIMEOUT(RT), .MAX_RETRY(MR), .ACK_VAL(ACK)
  ) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .data(data), .snd_cmd(snd_cmd),
    .clr_resp_rdy(clr_resp_rdy), .RX(rx), .TX(tx_w), .busy(busy), .frm_snt(frm_snt),
    .resp_rdy(resp_rdy), .resp(resp), .resp_ack(resp_ack), .timeout(timeout),
    .retry_cnt(retry_cnt), .o_dbg_state(dbg_state), .o_dbg_rx_state(dbg_rx_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int         checks  = 0;
  int         errors  = 0;
  int         frm_cnt = 0;
  bit         mon_en  = 1'b0;
  bit         rdy_seen = 1'b0;
  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    if (frm_snt === 1'b1) frm_cnt++;
    if (resp_rdy === 1'b1) rdy_seen = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- TX decoder / scoreboard ----------------
  initial begin : tx_mon
    logic [7:0] b;
    forever begin
      @(negedge tx_w);
      if (mon_en) begin
        repeat (BD/2) @(negedge clk);
        check("tx_start_bit", tx_w, 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(negedge clk);
          b[i] = tx_w;
        end
        repeat (BD) @(negedge clk);
        check("tx_stop_bit", tx_w, 1'b1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected_byte: got 0x%0h, expected no byte", b);
        end else begin
          check("tx_byte", b, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [7:0] c, input logic [8*DB-1:0] d);
    @(negedge clk);
    cmd = c; data = d; snd_cmd = 1'b1;
    @(negedge clk);
    snd_cmd = 1'b0;
  endtask

  task automatic uart_send(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BD) @(negedge clk);
    end
    rx = stop;
    repeat (BD) @(negedge clk);
    rx = 1'b1;
    repeat (BD) @(negedge clk);
  endtask

  task automatic wait_frm(input int limit, output int cyc);
    cyc = 0;
    while (cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (frm_snt === 1'b1) break;
    end
  endtask

  task automatic wait_idle(input int limit, output int cyc);
    cyc = 0;
    while (busy !== 1'b0 && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic wait_resp(input int limit);
    int cyc;
    cyc = 0;
    while (resp_rdy !== 1'b1 && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_resp_rdy = 1'b1;
    @(negedge clk);
    clr_resp_rdy = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] data;
    logic [7:0]  resp_b;
    logic [7:0]  b0, b1, b2;
    logic        ack;
  } vec_t;

  vec_t vecs[4];

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : main
    int cyc;
    int f0;
    int lows;

    vecs[0] = '{8'h01, 16'h0000, 8'hC0, 8'h01, 8'h00, 8'h00, 1'b0};
    vecs[1] = '{8'h02, 16'h1234, 8'hA5, 8'h02, 8'h12, 8'h34, 1'b1};
    vecs[2] = '{8'hFF, 16'hABCD, 8'hA5, 8'hFF, 8'hAB, 8'hCD, 1'b1};
    vecs[3] = '{8'h80, 16'h0001, 8'h3C, 8'h80, 8'h00, 8'h01, 1'b0};

    // ---------------- reset ----------------
    rst = 1'b1; cmd = '0; data = '0; snd_cmd = 1'b0; clr_resp_rdy = 1'b0; rx = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", tx_w, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_frm_snt", frm_snt, 1'b0);
    check("rst_resp_rdy", resp_rdy, 1'b0);
    check("rst_resp", resp, 8'h00);
    check("rst_resp_ack", resp_ack, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_retry_cnt", retry_cnt, 3'd0);
    rst = 1'b0;

    // Reset in the middle of a frame.
    send_cmd(8'hAA, 16'h5555);
    repeat (100) @(negedge clk);
    check("midrst_pre_busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_tx", tx_w, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_frm_snt", frm_snt, 1'b0);
    check("midrst_retry_cnt", retry_cnt, 3'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    f0 = frm_cnt;
    lows = 0;
    repeat (600) begin
      @(negedge clk);
      if (tx_w !== 1'b1) lows++;
    end
    check("midrst_tx_stays_idle", lows, 0);
    check("midrst_no_frm_snt", frm_cnt - f0, 0);
    check("midrst_busy_after", busy, 1'b0);
    mon_en = 1'b1;

    // ---------------- frame table ----------------
    for (int v = 0; v < 4; v++) begin
      exp_q.push_back(vecs[v].b0);
      exp_q.push_back(vecs[v].b1);
      exp_q.push_back(vecs[v].b2);
      f0 = frm_cnt;
      send_cmd(vecs[v].cmd, vecs[v].data);
      check("vec_busy_on_accept", busy, 1'b1);
      check("vec_resp_rdy_cleared", resp_rdy, 1'b0);
      wait_frm(600, cyc);
      check("vec_frm_latency", cyc, 480);
      uart_send(vecs[v].resp_b, 1'b1);
      wait_resp(300);
      check("vec_resp_rdy", resp_rdy, 1'b1);
      check("vec_resp", resp, vecs[v].resp_b);
      check("vec_resp_ack", resp_ack, vecs[v].ack);
      check("vec_retry_cnt", retry_cnt, 3'd0);
      check("vec_timeout", timeout, 1'b0);
      repeat (3) @(negedge clk);
      check("vec_busy_done", busy, 1'b0);
      check("vec_frm_count", frm_cnt - f0, 1);
      pulse_clr();
      check("vec_clr_resp_rdy", resp_rdy, 1'b0);
      check("vec_clr_resp_kept", resp, vecs[v].resp_b);
      check("vec_clr_ack_low", resp_ack, 1'b0);
    end

    // ---------------- timeout with retries ----------------
    repeat (3) begin
      exp_q.push_back(8'hC3); exp_q.push_back(8'h9A); exp_q.push_back(8'h7E);
    end
    f0 = frm_cnt;
    send_cmd(8'hC3, 16'h9A7E);
    wait_frm(600, cyc);
    check("to_frm1_latency", cyc, 480);
    wait_frm(3000, cyc);
    check("to_frm2_latency", cyc, 480 + RT);
    check("to_retry_cnt1", retry_cnt, 3'd1);
    wait_frm(3000, cyc);
    check("to_frm3_latency", cyc, 480 + RT);
    check("to_retry_cnt2", retry_cnt, 3'd2);
    wait_idle(3000, cyc);
    check("to_idle_latency", cyc, RT + 1);
    check("to_timeout", timeout, 1'b1);
    check("to_busy", busy, 1'b0);
    check("to_retry_final", retry_cnt, 3'd2);
    check("to_resp_rdy", resp_rdy, 1'b0);
    check("to_frm_count", frm_cnt - f0, 3);

    exp_q.push_back(8'h04); exp_q.push_back(8'h00); exp_q.push_back(8'h10);
    send_cmd(8'h04, 16'h0010);
    check("to_cleared_by_snd", timeout, 1'b0);
    check("to_retry_cleared", retry_cnt, 3'd0);
    wait_frm(600, cyc);
    uart_send(8'hA5, 1'b1);
    wait_idle(300, cyc);
    check("to_next_ack", resp_ack, 1'b1);
    pulse_clr();

    // ---------------- late response ----------------
    repeat (2) begin
      exp_q.push_back(8'h33); exp_q.push_back(8'h44); exp_q.push_back(8'h55);
    end
    f0 = frm_cnt;
    send_cmd(8'h33, 16'h4455);
    wait_frm(600, cyc);
    check("late_frm1_latency", cyc, 480);
    wait_frm(3000, cyc);
    check("late_frm2_latency", cyc, 480 + RT);
    uart_send(8'h5A, 1'b1);
    wait_idle(300, cyc);
    check("late_retry_cnt", retry_cnt, 3'd1);
    check("late_resp", resp, 8'h5A);
    check("late_resp_rdy", resp_rdy, 1'b1);
    check("late_timeout", timeout, 1'b0);
    check("late_busy", busy, 1'b0);
    check("late_frm_count", frm_cnt - f0, 2);
    pulse_clr();

    // ---------------- receiver corner cases ----------------
    exp_q.push_back(8'h61); exp_q.push_back(8'h62); exp_q.push_back(8'h63);
    send_cmd(8'h61, 16'h6263);
    wait_frm(600, cyc);
    @(negedge clk);
    rx = 1'b0;
    repeat (BD/4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("rx_glitch_no_byte", resp_rdy, 1'b0);
    check("rx_glitch_still_busy", busy, 1'b1);
    uart_send(8'hF0, 1'b0);
    repeat (20) @(negedge clk);
    check("rx_framing_dropped", resp_rdy, 1'b0);
    check("rx_framing_still_busy", busy, 1'b1);
    uart_send(8'h96, 1'b1);
    wait_resp(300);
    check("rx_valid_after_errors", resp, 8'h96);
    check("rx_valid_rdy", resp_rdy, 1'b1);
    check("rx_valid_retry", retry_cnt, 3'd0);
    wait_idle(300, cyc);
    pulse_clr();

    uart_send(8'h77, 1'b1);
    repeat (20) @(negedge clk);
    check("rx_unsolicited_rdy", resp_rdy, 1'b0);
    check("rx_unsolicited_resp", resp, 8'h96);

    // ---------------- snd_cmd while busy; clr coinciding with capture ----------------
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    f0 = frm_cnt;
    send_cmd(8'h11, 16'h2233);
    repeat (30) @(negedge clk);
    cmd = 8'hEE; data = 16'hFFFF; snd_cmd = 1'b1;
    @(negedge clk);
    snd_cmd = 1'b0;
    check("busy_snd_ignored_busy", busy, 1'b1);
    check("busy_snd_ignored_retry", retry_cnt, 3'd0);
    wait_frm(600, cyc);
    check("busy_snd_frm_latency", cyc, 449);
    clr_resp_rdy = 1'b1;
    rdy_seen = 1'b0;
    uart_send(8'h42, 1'b1);
    wait_idle(300, cyc);
    check("clr_vs_capture_seen", rdy_seen, 1'b1);
    check("clr_vs_capture_resp", resp, 8'h42);
    check("clr_held_clears", resp_rdy, 1'b0);
    check("busy_snd_frm_count", frm_cnt - f0, 1);
    clr_resp_rdy = 1'b0;

    repeat (50) @(negedge clk);
    check("tx_bytes_pending", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/comm_master_gen.md
Name: comm_master_gen

Overview:
Parametrised wireless-link command master for the QuadCopter bench and the ground-station FPGA. It frames a command byte plus DATA_BYTES payload bytes onto an 8N1 UART and waits for the copter's one-byte response. The response wait has a timeout with automatic resend. It supersedes the fixed 16-bit-payload CommMaster: payload width, baud, timeout, retry count and ack value are all configurable.

Parameters:
DATA_BYTES, 2, payload bytes after the command byte (1..4).
BAUD_DIV, 2604, clk cycles per UART bit (50 MHz / 19200). Minimum is 8.
RESP_TIMEOUT, 5000000, clk cycles to wait for a response after the last stop bit.
MAX_RETRY, 2, resends after the first attempt before declaring timeout (0..7).
ACK_VAL, 8'hA5, response value treated as positive acknowledge.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cmd  in  8  command byte, sampled when snd_cmd is accepted
data  in  8*DATA_BYTES  payload, sampled when snd_cmd is accepted
snd_cmd  in  1  one-cycle request to send a frame
clr_resp_rdy  in  1  clears resp_rdy
RX  in  1  UART receive from the copter (asynchronous)
TX  out  1  UART transmit to the copter
busy  out  1  high from snd_cmd acceptance until IDLE is re-entered
frm_snt  out  1  one-cycle pulse after the last stop bit of each transmitted frame, including resends
resp_rdy  out  1  response byte valid; sticky
resp  out  8  last accepted response byte
resp_ack  out  1  resp == ACK_VAL, qualified by resp_rdy
timeout  out  1  sticky; set when retries are exhausted
retry_cnt  out  3  resends performed for the current command

Behaviour:
- Reset (rst sampled high at a clk edge):
  - TX=1; busy=0; frm_snt=0; resp_rdy=0; resp=8'h00; resp_ack=0; timeout=0; retry_cnt=0.
  - FSM returns to IDLE; RX synchroniser flops are set to 1.
  - Applies mid-frame: TX returns high on the next cycle and no frm_snt is issued.
- Datapath:
  - On acceptance, {cmd, data} is latched into a shadow register.
  - Resends reuse the shadow copy, so input changes after acceptance have no effect.
- Transmit order: cmd byte first, then data bytes MSB byte first. Each byte is 8N1, LSB bit first, one stop bit, no idle gap between bytes.
- Frame length: (1+DATA_BYTES)*10*BAUD_DIV cycles. With the defaults this is 30 bit times.
- FSM states: IDLE, LOAD, TX_BYTE, WAIT_RESP, DONE.
  - IDLE: when snd_cmd=1, latch the shadow, set busy=1, clear resp_rdy and timeout, set retry_cnt=0, go to LOAD. snd_cmd is ignored in every state except IDLE.
  - LOAD: select the next byte, go to TX_BYTE. The start bit drives TX on the cycle after LOAD.
  - TX_BYTE: shift the byte out. After the stop bit, go to LOAD if bytes remain; otherwise pulse frm_snt, clear the timeout counter, and go to WAIT_RESP.
  - WAIT_RESP: on a valid received byte, latch resp, set resp_rdy, go to DONE. When the timeout counter reaches RESP_TIMEOUT-1: if retry_cnt < MAX_RETRY, increment retry_cnt and go to LOAD (resend the full frame); else set timeout and go to DONE.
  - DONE: busy=0 next cycle, go to IDLE.
- Receiver:
  - RX passes through a 2-flop synchroniser.
  - A start bit is detected on a falling edge and re-checked at the half-bit point; if RX is high there, it is a false start and is discarded.
  - Data bits are sampled mid-bit. A byte is valid only if the stop bit samples 1; a framing error discards the byte silently.
  - The receiver runs continuously. Bytes completing outside WAIT_RESP are dropped and do not touch resp or resp_rdy.
- resp_rdy:
  - Cleared by clr_resp_rdy or by snd_cmd acceptance.
  - If clr_resp_rdy coincides with a response capture, the capture wins and resp_rdy=1.
- resp_ack is combinational from registered resp and resp_rdy.
- Counters:
  - The baud counter is 12 bits wide; it wraps to 0 at BAUD_DIV-1.
  - The timeout counter is $clog2(RESP_TIMEOUT+1) bits wide and saturates; it does not wrap.

Test Plan:
- Reset test: BAUD_DIV=16, RESP_TIMEOUT=2000. Hold rst 3 cycles mid-frame -> TX=1 next cycle, busy=0, no frm_snt, all flags 0.
- Single frame: cmd=8'h01, data=16'h0000, copter model returns 8'hC0 -> TX bytes 01,00,00, frm_snt exactly once at cycle 480 after acceptance, resp=C0, resp_rdy=1, resp_ack=0, retry_cnt=0.
- Ack frame: cmd=8'h02, data=16'h1234, response A5 -> bytes on TX 02,12,34, resp_ack=1; asserting clr_resp_rdy drops resp_rdy next cycle while resp stays A5.
- Timeout with retry: MAX_RETRY=2, no response -> three identical frames, three frm_snt pulses, retry_cnt=2, timeout=1, busy=0. A later snd_cmd clears timeout.
- Late response: no reply to the first frame, reply 8'h5A during the second wait -> retry_cnt=1, resp=5A, timeout=0.
- Receiver edge cases:
  - 1/4-bit low glitch on RX -> no byte.
  - Byte with stop bit=0 -> dropped.
  - Unsolicited byte in IDLE -> resp_rdy stays 0.
  - snd_cmd pulsed while busy -> ignored, shadow unchanged.
